// File: rtl/hazard_scoreboard.sv
// Register scoreboard for RAW/WAW issue stalls with fixed- and variable-latency producers.
// Optional same-cycle writeback bypass: define HAZARD_SCOREBOARD_WB_BYPASS_EN.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int RAW_W  = 5,
  parameter int NUM_WB = 2,
  parameter int LAT_W  = 3,
  parameter int PERF_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [RAW_W-1:0]          id_rs1,
  input  logic [RAW_W-1:0]          id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [RAW_W-1:0]          id_rd,
  input  logic                      id_wen,
  input  logic [LAT_W-1:0]          id_lat,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*RAW_W-1:0]   wb_rd,
  output logic                      issue_ready,
  output logic                      stall,
  output logic [NREG-1:0]           busy_vec,
  output logic [$clog2(NREG):0]     pending_cnt,
  output logic [PERF_W-1:0]         stall_cycles,
  output logic                      wb_spurious
);
  localparam int NIDX  = 2**RAW_W;
  localparam int CNT_W = $clog2(NREG) + 1;

  logic [NREG-1:0]            busy_q, busy_d, var_q, var_d;
  logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]            wb_hit, clr, set, blk;
  logic [NIDX-1:0]            blk_ext, busy_ext, var_ext;
  logic [CNT_W-1:0]           pend_q, pend_d;
  logic [PERF_W-1:0]          sc_q;
  logic                       spur_q, spur_hit;
  logic                       raw, waw, fire;

  always_comb begin
    wb_hit = '0;
    for (int r = 1; r < NREG; r++)
      for (int k = 0; k < NUM_WB; k++)
        if (wb_valid[k] && wb_rd[k*RAW_W +: RAW_W] == RAW_W'(r)) wb_hit[r] = 1'b1;
  end

  always_comb begin
    clr = '0;
    for (int r = 1; r < NREG; r++)
      clr[r] = busy_q[r] & (var_q[r] ? wb_hit[r] : (cnt_q[r] == LAT_W'(1)));
  end

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
  assign blk = busy_q & ~clr;
`else
  assign blk = busy_q;
`endif

  assign blk_ext  = NIDX'(blk);
  assign busy_ext = NIDX'(busy_q);
  assign var_ext  = NIDX'(var_q);

  assign raw         = (id_use_rs1 & blk_ext[id_rs1]) | (id_use_rs2 & blk_ext[id_rs2]);
  assign waw         = id_wen & blk_ext[id_rd];
  assign issue_ready = ~rst_n | (~raw & ~waw & ~flush);
  assign stall       = id_valid & ~issue_ready;
  assign fire        = id_valid & issue_ready;

  // The counter holds cycles left after the issue cycle; lat=1 is forwardable
  // next cycle, so it never needs to occupy an entry.
  always_comb begin
    set = '0;
    if (fire && id_wen && id_lat != LAT_W'(1))
      for (int r = 1; r < NREG; r++)
        if (id_rd == RAW_W'(r)) set[r] = 1'b1;
  end

  always_comb begin
    busy_d = '0;
    var_d  = '0;
    cnt_d  = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_d[r] = busy_q[r];
      var_d[r]  = var_q[r];
      cnt_d[r]  = cnt_q[r];
      if (flush) begin
        busy_d[r] = 1'b0;
        var_d[r]  = 1'b0;
        cnt_d[r]  = '0;
      end else if (set[r]) begin
        busy_d[r] = 1'b1;
        var_d[r]  = (id_lat == '0);
        cnt_d[r]  = (id_lat == '0) ? '0 : id_lat - LAT_W'(1);
      end else if (clr[r]) begin
        busy_d[r] = 1'b0;
        var_d[r]  = 1'b0;
        cnt_d[r]  = '0;
      end else if (busy_q[r] && !var_q[r] && cnt_q[r] > LAT_W'(1)) begin
        cnt_d[r]  = cnt_q[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    logic [RAW_W-1:0] idx;
    idx      = '0;
    spur_hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      idx = wb_rd[k*RAW_W +: RAW_W];
      if (wb_valid[k] && idx != '0 && !(busy_ext[idx] && var_ext[idx])) spur_hit = 1'b1;
    end
    spur_hit = spur_hit & ~flush;
  end

  always_comb begin
    pend_d = '0;
    for (int r = 0; r < NREG; r++) pend_d = pend_d + CNT_W'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      var_q  <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      sc_q   <= '0;
      spur_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      var_q  <= var_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      if (stall && !flush && sc_q != '1) sc_q <= sc_q + PERF_W'(1);
      if (spur_hit) spur_q <= 1'b1;
    end
  end

  assign busy_vec     = busy_q;
  assign pending_cnt  = pend_q;
  assign stall_cycles = sc_q;
  assign wb_spurious  = spur_q;
endmodule
